alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/simplerisc_pkg.sv | 60 ++++++
 rtl/imm_ext.sv | 27 ++
 rtl/alu_issue.sv | 199 +++++++++++++++++++
 tb/tb_alu_issue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcode numbers, immediate modifier encodings,
// issue FSM states and small decode helpers used by alu_issue.
package simplerisc_pkg;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MOD  = 5'd4;
   localparam logic [4:0] OP_CMP  = 5'd5;
   localparam logic [4:0] OP_AND  = 5'd6;
   localparam logic [4:0] OP_OR   = 5'd7;
   localparam logic [4:0] OP_NOT  = 5'd8;
   localparam logic [4:0] OP_MOV  = 5'd9;
   localparam logic [4:0] OP_LSL  = 5'd10;
   localparam logic [4:0] OP_LSR  = 5'd11;
   localparam logic [4:0] OP_ASR  = 5'd12;
   localparam logic [4:0] OP_NOP  = 5'd13;
   localparam logic [4:0] OP_LD   = 5'd14;
   localparam logic [4:0] OP_ST   = 5'd15;
   localparam logic [4:0] OP_BEQ  = 5'd16;
   localparam logic [4:0] OP_BGT  = 5'd17;
   localparam logic [4:0] OP_B    = 5'd18;
   localparam logic [4:0] OP_CALL = 5'd19;
   localparam logic [4:0] OP_RET  = 5'd20;

   localparam logic [4:0] OP_LAST_LEGAL = OP_RET;

   localparam logic [1:0] MOD_SEXT = 2'b00;
   localparam logic [1:0] MOD_ZEXT = 2'b01;
   localparam logic [1:0] MOD_HIGH = 2'b10;
   localparam logic [1:0] MOD_RSVD = 2'b11;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      HOLD    = 2'd2,
      CMPWAIT = 2'd3
   } issue_state_e;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
   endfunction

   function automatic logic branch_resolve(input logic [4:0] op,
                                           input logic       fe,
                                           input logic       fgt);
      logic taken;
      case (op)
         OP_B, OP_CALL: taken = 1'b1;
         OP_BEQ:        taken = fe;
         OP_BGT:        taken = fgt;
         default:       taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extender: expands imm16 according to the two-bit
// modifier and flags the reserved encoding as illegal.
module imm_ext
   import simplerisc_pkg::*;
(
   input  logic [15:0] imm16,
   input  logic [1:0]  modifier,
   output logic [31:0] immx,
   output logic        illegal
);

   // Modifier decode; the reserved code yields zero data and raises illegal.
   always_comb begin
      immx    = 32'h0000_0000;
      illegal = 1'b0;
      case (modifier)
         MOD_SEXT: immx = {{16{imm16[15]}}, imm16};
         MOD_ZEXT: immx = {16'h0000, imm16};
         MOD_HIGH: immx = {imm16, 16'h0000};
         default: begin
            immx    = 32'h0000_0000;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// SimpleRISC ALU issue stage: decodes an instruction, issues it to the ALU with
// a valid/ready handshake, waits out mul/div/mod occupancy and compare results.
// Macro ALU_ISSUE_MULDIV_EN enables multi-cycle mul/div/mod issue; without it
// those opcodes are reported illegal.
module alu_issue
   import simplerisc_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [4:0]  aluSignals,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output logic [31:0] immx,
   output logic        isImmediate,
   output logic        issue_valid,
   input  logic        issue_ready,
   input  logic        cmp_valid,
   input  logic        cmp_e,
   input  logic        cmp_gt,
   output logic        flag_E,
   output logic        flag_GT,
   output logic        branch_taken,
   output logic        illegal
);

   issue_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             issue_valid_q, issue_valid_d;
   logic             instr_ready_q, instr_ready_d;
   logic             flag_e_q, flag_e_d;
   logic             flag_gt_q, flag_gt_d;
   logic [4:0]       alu_q, alu_d;
   logic [31:0]      op1_q, op1_d;
   logic [31:0]      op2_q, op2_d;
   logic [31:0]      immx_q, immx_d;
   logic             isimm_q, isimm_d;
   logic             br_q, br_d;
   logic             ill_q, ill_d;

   logic [4:0]       opcode_s;
   logic [31:0]      immx_s;
   logic             imm_ill_s;
   logic             op_ill_s;
   logic             md_ill_s;
   logic             dec_ill_s;
   logic             isimm_s;
   logic             unused_bits_s;

   assign opcode_s      = instr[31:27];
   assign unused_bits_s = ^instr[25:18];

   imm_ext u_imm_ext (
      .imm16    (instr[15:0]),
      .modifier (instr[17:16]),
      .immx     (immx_s),
      .illegal  (imm_ill_s)
   );

   // Decode-time illegality and immediate-select qualification.
   always_comb begin
      op_ill_s = (opcode_s > OP_LAST_LEGAL);
`ifdef ALU_ISSUE_MULDIV_EN
      md_ill_s = 1'b0;
`else
      md_ill_s = is_muldiv(opcode_s);
`endif
      dec_ill_s = op_ill_s | imm_ill_s | md_ill_s;
      if (opcode_s == OP_NOP) begin
         isimm_s = 1'b0;
      end else begin
         isimm_s = instr[26];
      end
   end

   // Issue FSM next-state, occupancy counter, flag update and output capture.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      flag_e_d  = flag_e_q;
      flag_gt_d = flag_gt_q;
      alu_d     = alu_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      immx_d    = immx_q;
      isimm_d   = isimm_q;
      br_d      = br_q;
      ill_d     = ill_q;

      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               alu_d   = opcode_s;
               op1_d   = rs1_data;
               op2_d   = rs2_data;
               immx_d  = immx_s;
               isimm_d = isimm_s;
               br_d    = branch_resolve(opcode_s, flag_e_q, flag_gt_q);
               ill_d   = dec_ill_s;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (issue_ready) begin
               if (ill_q) begin
                  state_d = IDLE;
               end else if (alu_q == OP_CMP) begin
                  state_d = CMPWAIT;
               end else if (is_muldiv(alu_q)) begin
                  state_d = HOLD;
                  cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = ISSUE;
            end
         end
         HOLD: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CMPWAIT: begin
            if (cmp_valid) begin
               flag_e_d  = cmp_e;
               flag_gt_d = cmp_gt;
               state_d   = IDLE;
            end else begin
               state_d = CMPWAIT;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      issue_valid_d = (state_d == ISSUE);
      instr_ready_d = (state_d == IDLE);
   end

   // State and output registers; synchronous reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= {CNT_W{1'b0}};
         issue_valid_q <= 1'b0;
         instr_ready_q <= 1'b1;
         flag_e_q      <= 1'b0;
         flag_gt_q     <= 1'b0;
         alu_q         <= 5'd0;
         op1_q         <= 32'h0000_0000;
         op2_q         <= 32'h0000_0000;
         immx_q        <= 32'h0000_0000;
         isimm_q       <= 1'b0;
         br_q          <= 1'b0;
         ill_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         issue_valid_q <= issue_valid_d;
         instr_ready_q <= instr_ready_d;
         flag_e_q      <= flag_e_d;
         flag_gt_q     <= flag_gt_d;
         alu_q         <= alu_d;
         op1_q         <= op1_d;
         op2_q         <= op2_d;
         immx_q        <= immx_d;
         isimm_q       <= isimm_d;
         br_q          <= br_d;
         ill_q         <= ill_d;
      end
   end

   assign instr_ready  = instr_ready_q;
   assign issue_valid  = issue_valid_q;
   assign flag_E       = flag_e_q;
   assign flag_GT      = flag_gt_q;
   assign aluSignals   = alu_q;
   assign op1          = op1_q;
   assign op2          = op2_q;
   assign immx         = immx_q;
   assign isImmediate  = isimm_q;
   assign branch_taken = br_q;
   assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with hand-computed expectations.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  aluSignals;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] immx;
   logic        isImmediate;
   logic        issue_valid;
   logic        issue_ready;
   logic        cmp_valid;
   logic        cmp_e;
   logic        cmp_gt;
   logic        flag_E;
   logic        flag_GT;
   logic        branch_taken;
   logic        illegal;

   int n_checks = 0;
   int n_err    = 0;

`ifdef ALU_ISSUE_MULDIV_EN
   localparam logic [31:0] EXP_DIV_HOLD = 32'd4;
   localparam logic [31:0] EXP_DIV_ILL  = 32'd0;
`else
   localparam logic [31:0] EXP_DIV_HOLD = 32'd0;
   localparam logic [31:0] EXP_DIV_ILL  = 32'd1;
`endif

   always #5 clk = ~clk;

   alu_issue #(.MULDIV_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .aluSignals   (aluSignals),
      .op1          (op1),
      .op2          (op2),
      .immx         (immx),
      .isImmediate  (isImmediate),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .cmp_valid    (cmp_valid),
      .cmp_e        (cmp_e),
      .cmp_gt       (cmp_gt),
      .flag_E       (flag_E),
      .flag_GT      (flag_GT),
      .branch_taken (branch_taken),
      .illegal      (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic i,
                                      input logic [1:0] md, input logic [15:0] imm);
      return {op, i, 8'h00, md, imm};
   endfunction

   task automatic accept(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!instr_ready && n < 50) begin
         step();
         n++;
      end
      chk("accept_ready", 32'(instr_ready), 32'd1);
      instr       = w;
      rs1_data    = a;
      rs2_data    = b;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
   endtask

   task automatic hs();
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
      issue_ready = 1'b0; cmp_valid = 1'b0; cmp_e = 1'b0; cmp_gt = 1'b0;
      repeat (3) step();
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_instr_ready", 32'(instr_ready), 32'd1);
      chk("rst_flags", {30'd0, flag_E, flag_GT}, 32'd0);
      chk("rst_br_ill", {30'd0, branch_taken, illegal}, 32'd0);
      chk("rst_alu", 32'(aluSignals), 32'd0);
      chk("rst_ops", op1 | op2 | immx, 32'd0);
      chk("rst_isimm", 32'(isImmediate), 32'd0);
      rst = 1'b0;
      step();

      // add r1,r2,#-5 then hold issue_ready low for 3 cycles
      chk("pre_issue_valid", 32'(issue_valid), 32'd0);
      accept(mk(5'd0, 1'b1, 2'b00, 16'hFFFB), 32'h1111_1111, 32'h2222_2222);
      chk("add_issue_valid", 32'(issue_valid), 32'd1);
      chk("add_alu", 32'(aluSignals), 32'd0);
      chk("add_isimm", 32'(isImmediate), 32'd1);
      chk("add_immx", immx, 32'hFFFF_FFFB);
      chk("add_op1", op1, 32'h1111_1111);
      chk("add_op2", op2, 32'h2222_2222);
      chk("add_illegal", 32'(illegal), 32'd0);
      instr = 32'hFFFF_FFFF; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", 32'(issue_valid), 32'd1);
         chk("stall_ready", 32'(instr_ready), 32'd0);
         chk("stall_immx", immx, 32'hFFFF_FFFB);
         chk("stall_op1", op1, 32'h1111_1111);
      end
      hs();
      chk("add_done_ready", 32'(instr_ready), 32'd1);
      chk("add_done_valid", 32'(issue_valid), 32'd0);

      // cmp_valid outside CMPWAIT must be ignored
      cmp_valid = 1'b1; cmp_e = 1'b1; cmp_gt = 1'b1;
      step();
      cmp_valid = 1'b0;
      chk("idle_cmp_ignored", {30'd0, flag_E, flag_GT}, 32'd0);

      // cmp, result two cycles later, then dependent branches
      accept(mk(5'd5, 1'b0, 2'b00, 16'h0000), 32'h5, 32'h5);
      hs();
      chk("cmpwait_ready", 32'(instr_ready), 32'd0);
      cmp_e = 1'b1; cmp_gt = 1'b0;
      repeat (2) step();
      chk("cmpwait_still", 32'(instr_ready), 32'd0);
      cmp_valid = 1'b1;
      step();
      cmp_valid = 1'b0;
      chk("cmp_flag_E", 32'(flag_E), 32'd1);
      chk("cmp_flag_GT", 32'(flag_GT), 32'd0);
      chk("cmp_done_ready", 32'(instr_ready), 32'd1);
      accept(mk(5'd16, 1'b1, 2'b00, 16'h0010), 32'h0, 32'h0);
      chk("beq_taken", 32'(branch_taken), 32'd1);
      hs();
      accept(mk(5'd17, 1'b1, 2'b00, 16'h0010), 32'h0, 32'h0);
      chk("bgt_taken", 32'(branch_taken), 32'd0);
      hs();
      accept(mk(5'd18, 1'b1, 2'b00, 16'h0010), 32'h0, 32'h0);
      chk("b_taken", 32'(branch_taken), 32'd1);
      hs();
      accept(mk(5'd1, 1'b0, 2'b00, 16'h0000), 32'h0, 32'h0);
      chk("sub_taken", 32'(branch_taken), 32'd0);
      hs();

      // div occupancy
      accept(mk(5'd3, 1'b0, 2'b00, 16'h0000), 32'd100, 32'd7);
      chk("div_illegal", 32'(illegal), EXP_DIV_ILL);
      hs();
      chk("div_valid_low", 32'(issue_valid), 32'd0);
      n = 0;
      while (!instr_ready && n < 40) begin
         step();
         n++;
      end
      chk("div_hold_cycles", 32'(n), EXP_DIV_HOLD);

      // immediate modifiers, illegal opcode, nop
      accept(mk(5'd0, 1'b1, 2'b11, 16'h1234), 32'h0, 32'h0);
      chk("mod11_illegal", 32'(illegal), 32'd1);
      hs();
      chk("mod11_idle", 32'(instr_ready), 32'd1);
      accept(mk(5'd25, 1'b0, 2'b00, 16'h0000), 32'h0, 32'h0);
      chk("op25_illegal", 32'(illegal), 32'd1);
      chk("op25_alu", 32'(aluSignals), 32'd25);
      hs();
      chk("op25_idle", 32'(instr_ready), 32'd1);
      accept(mk(5'd9, 1'b1, 2'b10, 16'h1234), 32'h0, 32'h0);
      chk("mod10_immx", immx, 32'h1234_0000);
      chk("mod10_illegal", 32'(illegal), 32'd0);
      hs();
      accept(mk(5'd9, 1'b1, 2'b01, 16'h8001), 32'h0, 32'h0);
      chk("mod01_immx", immx, 32'h0000_8001);
      hs();
      accept(mk(5'd0, 1'b1, 2'b00, 16'h7FFF), 32'h0, 32'h0);
      chk("sext_pos_immx", immx, 32'h0000_7FFF);
      hs();
      accept(mk(5'd13, 1'b1, 2'b00, 16'h0000), 32'h0, 32'h0);
      chk("nop_isimm", 32'(isImmediate), 32'd0);
      chk("nop_alu", 32'(aluSignals), 32'd13);
      chk("nop_valid", 32'(issue_valid), 32'd1);
      hs();

      // reset during CMPWAIT with a simultaneous compare result
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_flag_E", 32'(flag_E), 32'd0);
      accept(mk(5'd5, 1'b0, 2'b00, 16'h0000), 32'h9, 32'h3);
      hs();
      rst = 1'b1; cmp_valid = 1'b1; cmp_e = 1'b1; cmp_gt = 1'b1;
      step();
      rst = 1'b0; cmp_valid = 1'b0;
      chk("rstcmp_flags", {30'd0, flag_E, flag_GT}, 32'd0);
      chk("rstcmp_ready", 32'(instr_ready), 32'd1);
      chk("rstcmp_valid", 32'(issue_valid), 32'd0);
      cmp_valid = 1'b1;
      step();
      cmp_valid = 1'b0;
      chk("rstcmp_late", {30'd0, flag_E, flag_GT}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
